// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector: compares the newest CUR_LEN
// sampled bits against a loadable pattern and keeps a saturating hit count.
module seq_detect_param #(
  parameter int unsigned        MAX_LEN     = 16,
  parameter int unsigned        DEF_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT     = MAX_LEN'(16'h00AB),
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int unsigned        CNT_W       = 16,
  localparam int unsigned       LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               D_IN,
  input  logic               CFG_LD,
  input  logic [MAX_LEN-1:0] CFG_PAT,
  input  logic [LW-1:0]      CFG_LEN,
  input  logic               CFG_OVERLAP,
  input  logic               CNT_CLR,
  output logic               MATCH,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               CFG_ERR,
  output logic [LW-1:0]      CUR_LEN
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      fill;
  logic               overlap;

  logic               cfg_ok;
  logic               load_ok;
  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;
  logic               hit;

  // Match is judged on the post-shift history so MATCH lands one cycle after the last bit.
  always_comb begin
    cfg_ok   = (CFG_LEN != '0) && (CFG_LEN <= LW'(MAX_LEN));
    load_ok  = CFG_LD && cfg_ok;
    hist_sh  = {hist[MAX_LEN-2:0], D_IN};
    fill_inc = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < CUR_LEN);
    end
    hit = EN && !load_ok && (fill_inc >= CUR_LEN) &&
          (((hist_sh ^ pat) & len_mask) == '0);
  end

  // Configuration, history and fill tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= DEF_PAT;
      CUR_LEN <= LW'(DEF_LEN);
      overlap <= DEF_OVERLAP;
      MATCH   <= 1'b0;
      CFG_ERR <= 1'b0;
    end else if (load_ok) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= CFG_PAT;
      CUR_LEN <= CFG_LEN;
      overlap <= CFG_OVERLAP;
      MATCH   <= 1'b0;
      CFG_ERR <= 1'b0;
    end else begin
      MATCH   <= hit;
      CFG_ERR <= CFG_LD;
      if (EN) begin
        hist <= hist_sh;
        fill <= (hit && !overlap) ? '0 : fill_inc;
      end
    end
  end

  // Saturating match counter; a clear coincident with a hit leaves one count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MATCH_CNT <= '0;
    end else if (CNT_CLR) begin
      MATCH_CNT <= hit ? CNT_W'(1) : '0;
    end else if (hit && (MATCH_CNT != {CNT_W{1'b1}})) begin
      MATCH_CNT <= MATCH_CNT + CNT_W'(1);
    end
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised, run-time-programmable serial pattern detector. Successor to the fixed 8-bit "10101011" detector.
- Samples one bit per enabled clock from the serial input stream. Compares the most recent N bits against a loadable pattern of length 1..MAX_LEN.
- Pulses MATCH for one cycle per detection and keeps a saturating match count.
- Supports overlapping (repetition) and non-overlapping detection modes. Sits between the pattern-file stimulus path and the output logger.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (2..32).
- DEF_LEN, 8, pattern length after reset (1..MAX_LEN).
- DEF_PAT, 16'h00AB, pattern after reset, right-aligned. Bit DEF_LEN-1 is the first bit received; bit 0 is the last.
- DEF_OVERLAP, 1, mode after reset: 1 = overlapping, 0 = non-overlapping.
- CNT_W, 16, width of the match counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  bit-valid. D_IN is sampled only when EN=1.
- D_IN  in  1  serial data bit.
- CFG_LD  in  1  one-cycle strobe that loads the configuration.
- CFG_PAT  in  MAX_LEN  new pattern, right-aligned, MSB-first as for DEF_PAT.
- CFG_LEN  in  $clog2(MAX_LEN+1)  new pattern length.
- CFG_OVERLAP  in  1  new mode.
- CNT_CLR  in  1  clears MATCH_CNT.
- MATCH  out  1  one-cycle detection pulse, registered.
- MATCH_CNT  out  CNT_W  saturating detection count.
- CFG_ERR  out  1  one-cycle pulse on a rejected load.
- CUR_LEN  out  $clog2(MAX_LEN+1)  active pattern length.

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high. All state is registered.
- Reset values (RST=1 at a rising edge):
  - MATCH=0, MATCH_CNT=0, CFG_ERR=0.
  - History shift register = 0. Fill counter = 0.
  - Pattern = DEF_PAT, length (CUR_LEN) = DEF_LEN, mode = DEF_OVERLAP.
  - RST overrides every other input, including mid-stream and mid-load.
- Data path: MAX_LEN-bit history shift register plus a fill counter (saturates at MAX_LEN).
  - On an edge with EN=1: history <= {history[MAX_LEN-2:0], D_IN}; fill counter increments.
- Match condition, evaluated on the post-shift history:
  - fill >= CUR_LEN, and
  - history[CUR_LEN-1:0] == pattern[CUR_LEN-1:0]. Bits above CUR_LEN are ignored.
- Latency: MATCH=1 in the cycle immediately after the edge that samples the final pattern bit, for exactly one cycle.
- EN=0: history, fill and counter are held; MATCH=0 that cycle. Gaps in EN do not break a partial match.
- Overlapping mode: history is kept after a match, so pattern suffix/prefix reuse produces back-to-back matches.
- Non-overlapping mode: on a match, the fill counter is zeroed on the same edge. The next match needs CUR_LEN fresh bits.
- Counter:
  - MATCH_CNT increments on each match edge and saturates at all-ones.
  - CNT_CLR zeroes it. If CNT_CLR and a match occur on the same edge, the result is 1.
- Configuration load (CFG_LD=1):
  - Valid iff 1 <= CFG_LEN <= MAX_LEN.
  - Valid load: pattern, length and mode update; history and fill clear; no match evaluated that cycle; the D_IN bit on that edge is discarded even if EN=1.
  - Invalid load: configuration unchanged, history untouched, the EN bit is processed normally, CFG_ERR pulses for one cycle.
- Length 1: every matching bit produces a MATCH, in either mode.
- Implementation: a compare-based datapath is the required form. No per-state FSM encoding for each pattern.

Test Plan:
- Reset defaults, EN=1, stream 1,0,1,0,1,0,1,1 -> MATCH=0 for the first 7 bits; MATCH=1 only in the cycle after bit 8; MATCH_CNT=1.
- Overlap, default pattern, stream 101010110101011 (15 bits) -> MATCH after bits 8 and 15; MATCH_CNT=2. Same stream after CFG_LD with OVERLAP=0, PAT=0xAB, LEN=8 -> single MATCH after bit 8; MATCH_CNT=1.
- EN gaps: default pattern with EN=0 for 3 cycles between bits 4 and 5 -> MATCH=0 during the gaps; MATCH after bit 8 as usual.
- Reprogram: CFG_LD with LEN=3, PAT=3'b110, OVERLAP=1, then stream 1101101 -> MATCH after bits 3 and 6. CFG_LD with LEN=0 or LEN=MAX_LEN+1 -> CFG_ERR pulse; CUR_LEN unchanged; detection continues.
- Counter: CNT_W=2, 5 matches -> MATCH_CNT=3 (saturated). CNT_CLR coincident with a match -> MATCH_CNT=1.
- Reset mid-pattern: RST after bit 6 of 10101011, then the full pattern -> no MATCH from the partial prefix; MATCH after 8 fresh bits; configuration back to defaults.
